puf_response_collector: RTL and testbench

Sequencing and capture stage that sits directly downstream of the race arbiter in the arbiter PUF datapath, and upstream of it on the challenge side. On a start request it generates a sequence of 64-bit challenges from an LFSR seeded by the host. For each challenge it launches a race, waits a fixed settle window, enables the race arbiter for one sample cycle and shifts the arbiter's output bit into a response register. After RESP_BITS races it publishes the full response word and pulses done.

---
 rtl/puf_response_collector.sv | 110 +++++++++++
 tb/tb_puf_response_collector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_collector.sv
// Arbiter-PUF challenge sequencer and response capture.
// LFSR challenges, timed launch/settle/sample, MSB-first response.
module puf_response_collector #(
    parameter int RESP_BITS     = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [63:0]          seed,
    input  logic                 arb_out,
    output logic [63:0]          challenge,
    output logic                 launch,
    output logic                 arb_enable,
    output logic [RESP_BITS-1:0] response,
    output logic                 busy,
    output logic                 done
);
    localparam int BW = $clog2(RESP_BITS);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(RESP_BITS - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        SAMPLE,
        ADVANCE,
        DONE
    } state_t;

    state_t               state;
    logic [BW-1:0]        bit_cnt;
    logic [SW-1:0]        settle_cnt;
    logic [RESP_BITS-1:0] shreg;
    logic [RESP_BITS-1:0] shreg_nxt;
    logic                 fb;

    assign shreg_nxt = {shreg[RESP_BITS-2:0], arb_out};
    // x^64 + x^63 + x^61 + x^60 + 1
    assign fb = challenge[63] ^ challenge[62]
              ^ challenge[60] ^ challenge[59];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            shreg      <= '0;
            challenge  <= '0;
            launch     <= 1'b0;
            arb_enable <= 1'b0;
            response   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // all-zero would lock the LFSR
                        challenge <= (seed == 64'd0) ? 64'd1 : seed;
                        bit_cnt   <= '0;
                        shreg     <= '0;
                        launch    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    launch     <= 1'b0;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        arb_enable <= 1'b1;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    arb_enable <= 1'b0;
                    shreg      <= shreg_nxt;
                    if (bit_cnt == BIT_LAST) begin
                        response <= shreg_nxt;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    challenge <= {challenge[62:0], fb};
                    bit_cnt   <= bit_cnt + 1'b1;
                    launch    <= 1'b1;
                    state     <= LAUNCH;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_collector.sv
// Randomized bench for puf_response_collector against a
// cycle-timeline reference model built from the run schedule.
module tb_puf_response_collector;
    localparam int R = 32;
    localparam int S = 4;
    localparam int P = S + 3;
    localparam int T = R * P;
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  seed = 64'd0;
    logic         arb_out = 1'b0;
    logic [63:0]  challenge;
    logic         launch;
    logic         arb_enable;
    logic [R-1:0] response;
    logic         busy;
    logic         done;

    int n_chk = 0;
    int n_err = 0;
    int n_launch;
    int n_en;
    int n_done;
    logic [63:0]  obs_ch [3];
    logic [R-1:0] prev_resp = '0;

    puf_response_collector #(
        .RESP_BITS    (R),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .arb_out   (arb_out),
        .challenge (challenge),
        .launch    (launch),
        .arb_enable(arb_enable),
        .response  (response),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {60'd0, launch, arb_enable, busy, done}, 64'd0);
        chk(tag, challenge, 64'd0);
        chk(tag, 64'(response), 64'd0);
    endtask

    function automatic logic [63:0] lfsr_next(input logic [63:0] c);
        return {c[62:0], ^(c & TAPS)};
    endfunction

    // pat[i] is the arbiter decision of race i (time order)
    task automatic run_one(input logic [63:0] sd, input logic [R-1:0] pat,
                           input int dist_c, input int rst_c,
                           input bit hold);
        logic [63:0] lf [R];
        logic [63:0] c;
        logic [R-1:0] exp_resp;
        logic [R-1:0] e_resp;
        int i, ph;
        bit live, e_launch, e_en, e_busy, e_done;
        c = (sd == 64'd0) ? 64'd1 : sd;
        exp_resp = '0;
        for (int k = 0; k < R; k++) begin
            lf[k] = c;
            c = lfsr_next(c);
            exp_resp = (exp_resp << 1) | R'(pat[k]);
        end
        n_launch = 0;
        n_en = 0;
        n_done = 0;
        for (int k = 0; k < 3; k++) obs_ch[k] = 64'hx;
        seed = sd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = hold;
        for (int cy = 1; cy <= T + 1; cy++) begin
            @(negedge clk);
            i = (cy - 1) / P;
            if (i > R - 1) i = R - 1;
            ph = (cy - 1) % P;
            live = cy < T;
            e_launch = live && ph == 0;
            e_en = live && ph == S + 1;
            e_busy = cy <= T;
            e_done = cy == T;
            e_resp = (cy >= T) ? exp_resp : prev_resp;
            chk("flags", {60'd0, launch, arb_enable, busy, done},
                {60'd0, e_launch, e_en, e_busy, e_done});
            chk("challenge", challenge, lf[i]);
            chk("response", 64'(response), 64'(e_resp));
            n_launch += int'(launch);
            n_en += int'(arb_enable);
            n_done += int'(done);
            if (e_launch && i < 3) obs_ch[i] = challenge;
            if (cy == rst_c) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                chk_zero("rst_async");
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    arb_out = 1'($urandom);
                    chk_zero("rst_hold");
                    n_done += int'(done);
                end
                rst_n = 1'b1;
                prev_resp = '0;
                return;
            end
            arb_out = e_en ? pat[i] : 1'($urandom);
            if (cy == dist_c) begin
                start = 1'b1;
                seed = {$urandom, $urandom};
            end else if (cy == dist_c + 1) begin
                start = hold;
            end
        end
        prev_resp = exp_resp;
    endtask

    initial begin
        logic [R-1:0] rp;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'($urandom);
            seed = {$urandom, $urandom};
            arb_out = 1'($urandom);
            chk_zero("reset");
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            arb_out = 1'($urandom);
            chk_zero("idle");
        end

        run_one(64'h1, '1, -1, -1, 1'b0);
        chk("ones_launch", 64'(n_launch), 64'd32);
        chk("ones_enable", 64'(n_en), 64'd32);
        chk("ones_done", 64'(n_done), 64'd1);
        chk("ones_resp", 64'(response), 64'hFFFF_FFFF);
        chk("lfsr_r0", obs_ch[0], 64'h1);
        chk("lfsr_r1", obs_ch[1], 64'h2);
        chk("lfsr_r2", obs_ch[2], 64'h4);
        @(negedge clk);

        run_one({$urandom, $urandom}, 32'h5555_5555, -1, -1, 1'b0);
        chk("alt_resp", 64'(response), 64'hAAAA_AAAA);
        @(negedge clk);
        run_one({$urandom, $urandom}, 32'hAAAA_AAAA, -1, -1, 1'b0);
        chk("alt2_resp", 64'(response), 64'h5555_5555);
        @(negedge clk);

        run_one(64'h0, R'($urandom), -1, -1, 1'b0);
        chk("seed0_r0", obs_ch[0], 64'h1);
        @(negedge clk);

        run_one({$urandom, $urandom}, R'($urandom), 50, -1, 1'b0);
        chk("busy_start_done", 64'(n_done), 64'd1);
        @(negedge clk);

        run_one({$urandom, $urandom}, R'($urandom), -1, 100, 1'b0);
        chk("rst_nodone", 64'(n_done), 64'd0);
        @(negedge clk);
        run_one(64'h1, R'($urandom), -1, -1, 1'b0);
        chk("post_rst_done", 64'(n_done), 64'd1);
        chk("post_rst_r1", obs_ch[1], 64'h2);
        @(negedge clk);

        run_one({$urandom, $urandom}, R'($urandom), -1, -1, 1'b1);
        chk("hold_done_a", 64'(n_done), 64'd1);
        run_one({$urandom, $urandom}, R'($urandom), -1, -1, 1'b0);
        chk("hold_done_b", 64'(n_done), 64'd1);
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            rp = R'($urandom);
            run_one({$urandom, $urandom}, rp, -1, -1, 1'b0);
            chk("rand_done", 64'(n_done), 64'd1);
            repeat (1 + ($urandom % 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
